// File: rtl/router_dest_reader.sv
// rtl/router_dest_reader.sv - destination-side packet reader for one router output port
//
// Drains one packet per visit (header, len payload bytes, parity) from the router
// port FIFO, checks the header address and the parity, streams the payload to a
// local sink and reports per-packet status with a one-cycle pkt_done pulse.
//
// Ports:
//   clock, resetn            clock, synchronous active-low reset
//   valid_out                router port FIFO not empty
//   data_out[7:0]            router port FIFO data, valid the cycle after a read
//   sink_ready               local sink can take a byte this cycle
//   read_enb                 read strobe to the router port FIFO
//   byte_out[7:0], byte_vld  payload byte stream to the sink
//   busy                     packet in progress
//   pkt_done                 end-of-packet pulse (also for aborted packets)
//   pkt_len[5:0]             header length of the last packet
//   par_err, addr_err, timeout_err   packet status, valid with pkt_done
module router_dest_reader #(
  parameter logic [1:0] PORT_ID     = 2'b00,
  parameter int         WAIT_CYCLES = 4,
  parameter int         TIMEOUT     = 32
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       valid_out,
  input  logic [7:0] data_out,
  input  logic       sink_ready,
  output logic       read_enb,
  output logic [7:0] byte_out,
  output logic       byte_vld,
  output logic       busy,
  output logic       pkt_done,
  output logic [5:0] pkt_len,
  output logic       par_err,
  output logic       addr_err,
  output logic       timeout_err
);

  // The first read must land inside the router's 30-cycle soft-reset window.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 28 || TIMEOUT < 1) begin : g_bad_cfg
    $error("router_dest_reader: WAIT_CYCLES must be 0..28 and TIMEOUT at least 1");
  end

  localparam int            TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [4:0]    WAIT_LOAD = (WAIT_CYCLES > 0) ? 5'(WAIT_CYCLES - 1) : 5'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HDR_RD,
    S_HDR_CAP,
    S_PAY,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [4:0]    r_wait;
  logic [TW-1:0] r_to_cnt;
  logic [6:0]    r_issue;     // reads still to issue (payload + parity)
  logic [6:0]    r_recv;      // bytes still to receive (payload + parity)
  logic          r_inflight;  // a PAY read was accepted last cycle, data_out holds its byte
  logic [7:0]    r_acc;
  logic [5:0]    r_len;
  logic [7:0]    r_byte_out;
  logic          r_byte_vld;
  logic          r_par_err;
  logic          r_addr_err;
  logic          r_to_err;

  logic          w_rd_hdr;
  logic          w_rd_pay;
  logic          w_owed;
  logic          w_to_hit;
  logic          w_last_byte;

  assign w_rd_hdr    = (r_state == S_HDR_RD) && valid_out && sink_ready;
  // Reads stop once len+1 have been issued: the next packet may already sit in the FIFO.
  assign w_rd_pay    = (r_state == S_PAY) && valid_out && sink_ready && (r_issue != 7'd0);
  assign w_owed      = (r_state == S_HDR_RD) || ((r_state == S_PAY) && (r_issue != 7'd0));
  // Only an empty FIFO counts towards the timeout; sink stalls never do.
  assign w_to_hit    = w_owed && !valid_out && (r_to_cnt == TO_LAST);
  assign w_last_byte = (r_state == S_PAY) && r_inflight && (r_recv == 7'd1);

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (valid_out) begin
          w_next = (WAIT_CYCLES == 0) ? S_HDR_RD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!valid_out) begin
          w_next = S_IDLE;
        end else if (r_wait == 5'd0) begin
          w_next = S_HDR_RD;
        end
      end
      S_HDR_RD: begin
        if (w_to_hit) begin
          w_next = S_DONE;
        end else if (w_rd_hdr) begin
          w_next = S_HDR_CAP;
        end
      end
      S_HDR_CAP: w_next = S_PAY;
      S_PAY: begin
        if (w_last_byte || w_to_hit) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    read_enb = w_rd_hdr || w_rd_pay;
    busy     = (r_state != S_IDLE);
    pkt_done = (r_state == S_DONE);
  end

  // Datapath: counters, header/parity capture, payload stream, status
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wait     <= '0;
      r_to_cnt   <= '0;
      r_issue    <= '0;
      r_recv     <= '0;
      r_inflight <= 1'b0;
      r_acc      <= '0;
      r_len      <= '0;
      r_byte_out <= '0;
      r_byte_vld <= 1'b0;
      r_par_err  <= 1'b0;
      r_addr_err <= 1'b0;
      r_to_err   <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      r_inflight <= w_rd_pay;

      if (w_rd_hdr || w_rd_pay || w_to_hit || !w_owed) begin
        r_to_cnt <= '0;
      end else if (!valid_out) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (valid_out) begin
            r_wait     <= WAIT_LOAD;
            r_par_err  <= 1'b0;
            r_addr_err <= 1'b0;
            r_to_err   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_wait != 5'd0) begin
            r_wait <= r_wait - 5'd1;
          end
        end
        S_HDR_CAP: begin
          r_len      <= data_out[7:2];
          r_addr_err <= (data_out[1:0] != PORT_ID);
          r_acc      <= data_out;
          r_issue    <= {1'b0, data_out[7:2]} + 7'd1;
          r_recv     <= {1'b0, data_out[7:2]} + 7'd1;
        end
        S_PAY: begin
          if (w_rd_pay) begin
            r_issue <= r_issue - 7'd1;
          end
          if (r_inflight) begin
            r_recv <= r_recv - 7'd1;
            if (r_recv > 7'd1) begin
              r_byte_out <= data_out;
              r_byte_vld <= 1'b1;
              r_acc      <= r_acc ^ data_out;
            end else begin
              r_par_err <= (data_out != r_acc);
            end
          end
        end
        default: ;
      endcase

      if (w_to_hit) begin
        r_to_err <= 1'b1;
      end
    end
  end

  assign byte_out    = r_byte_out;
  assign byte_vld    = r_byte_vld;
  assign pkt_len     = r_len;
  assign par_err     = r_par_err;
  assign addr_err    = r_addr_err;
  assign timeout_err = r_to_err;

endmodule

// File: tb/tb_router_dest_reader.sv
// tb/tb_router_dest_reader.sv - scoreboard bench for router_dest_reader
module tb_router_dest_reader;

  localparam logic [1:0] PORT_ID     = 2'b00;
  localparam int         WAIT_CYCLES = 4;
  localparam int         TIMEOUT     = 32;

  logic       clock = 1'b0;
  logic       resetn;
  logic       valid_out;
  logic [7:0] data_out;
  logic       sink_ready;
  logic       read_enb;
  logic [7:0] byte_out;
  logic       byte_vld;
  logic       busy;
  logic       pkt_done;
  logic [5:0] pkt_len;
  logic       par_err;
  logic       addr_err;
  logic       timeout_err;

  router_dest_reader #(
    .PORT_ID    (PORT_ID),
    .WAIT_CYCLES(WAIT_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .sink_ready (sink_ready),
    .read_enb   (read_enb),
    .byte_out   (byte_out),
    .byte_vld   (byte_vld),
    .busy       (busy),
    .pkt_done   (pkt_done),
    .pkt_len    (pkt_len),
    .par_err    (par_err),
    .addr_err   (addr_err),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  logic [7:0] fifo[$];
  logic [7:0] exp_bytes[$];
  logic [8:0] exp_stat[$];   // {len, par_err, addr_err, timeout_err}
  logic [7:0] pay_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int read_cnt    = 0;
  int bytes_seen  = 0;
  int done_cnt    = 0;
  int over_rd     = 0;
  int lat_cnt     = 0;
  bit lat_armed   = 1'b0;
  bit lat_en      = 1'b0;
  bit rand_sink   = 1'b0;
  bit rand_gap    = 1'b0;
  bit hold_low    = 1'b0;
  bit rd_now      = 1'b0;
  logic [7:0] e_byte;
  logic [8:0] e_stat;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Router port FIFO: read data appears the cycle after an accepted read.
  always begin
    @(negedge clock);
    rd_now = read_enb;
    @(posedge clock);
    #1;
    if (rd_now) begin
      if (fifo.size() == 0) over_rd++;
      else data_out = fifo.pop_front();
    end else begin
      data_out = 8'($urandom);
    end
    if (rand_sink) sink_ready = ($urandom_range(0, 3) != 0);
    hold_low  = rand_gap && ($urandom_range(0, 7) == 0);
    valid_out = (fifo.size() != 0) && !hold_low;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a byte or a status.
  always @(negedge clock) begin
    if (!resetn) begin
      lat_armed = 1'b0;
    end else begin
      if (read_enb) read_cnt++;
      if (byte_vld) begin
        bytes_seen++;
        if (exp_bytes.size() == 0) begin
          chk("byte_unexpected", {24'd0, byte_out}, 32'hFFFF_FFFF);
        end else begin
          e_byte = exp_bytes.pop_front();
          chk("byte_out", {24'd0, byte_out}, {24'd0, e_byte});
        end
      end
      if (pkt_done) begin
        done_cnt++;
        if (exp_stat.size() == 0) begin
          chk("pkt_done_unexpected", 32'(pkt_len), 32'hFFFF_FFFF);
        end else begin
          e_stat = exp_stat.pop_front();
          chk("pkt_len", 32'(pkt_len), 32'(e_stat[8:3]));
          chk("par_err", 32'(par_err), 32'(e_stat[2]));
          chk("addr_err", 32'(addr_err), 32'(e_stat[1]));
          chk("timeout_err", 32'(timeout_err), 32'(e_stat[0]));
        end
      end
      if (!lat_en) begin
        lat_armed = 1'b0;
      end else if (lat_armed) begin
        lat_cnt++;
        if (read_enb) begin
          chk("hdr_latency", lat_cnt, WAIT_CYCLES + 1);
          lat_armed = 1'b0;
        end else if (lat_cnt > 40) begin
          chk("hdr_latency", lat_cnt, WAIT_CYCLES + 1);
          lat_armed = 1'b0;
        end
      end else if (!busy && valid_out) begin
        lat_armed = 1'b1;
        lat_cnt   = 0;
      end
    end
  end

  // Queues one packet. Only the first npay payload bytes are sent; a packet with
  // npay < len has no parity and is expected to end by timeout.
  task automatic send_pkt(input logic [1:0] addr, input int len, input logic [7:0] bad_mask,
                          input int npay);
    logic [7:0] hdr;
    logic [7:0] par;
    logic [7:0] b;
    logic [5:0] l6;
    l6  = len[5:0];
    hdr = {l6, addr};
    par = hdr;
    fifo.push_back(hdr);
    for (int i = 0; i < len; i++) begin
      b   = (i < pay_q.size()) ? pay_q[i] : 8'($urandom);
      par = par ^ b;
      if (i < npay) begin
        fifo.push_back(b);
        exp_bytes.push_back(b);
      end
    end
    if (npay >= len) begin
      fifo.push_back(par ^ bad_mask);
      exp_stat.push_back({l6, (bad_mask != 8'h00), (addr != PORT_ID), 1'b0});
    end else begin
      exp_stat.push_back({l6, 1'b0, (addr != PORT_ID), 1'b1});
    end
    pay_q.delete();
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < 6000) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (done_cnt < target) begin
      miscompares++;
      $display("FAIL %s: pkt_done count %0d, expected %0d", name, done_cnt, target);
    end
    @(posedge clock);
    #2;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_read_enb"}, 32'(read_enb), 0);
    chk({tag, "_byte_vld"}, 32'(byte_vld), 0);
    chk({tag, "_byte_out"}, 32'(byte_out), 0);
    chk({tag, "_pkt_done"}, 32'(pkt_done), 0);
    chk({tag, "_pkt_len"}, 32'(pkt_len), 0);
    chk({tag, "_par_err"}, 32'(par_err), 0);
    chk({tag, "_addr_err"}, 32'(addr_err), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rc0;
    int bc0;
    int d0;
    int n;
    int low_cnt;
    int exp_reads;
    int len;

    resetn     = 1'b0;
    valid_out  = 1'b0;
    sink_ready = 1'b0;
    data_out   = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle("reset");
    @(posedge clock);
    #2;
    resetn     = 1'b1;
    sink_ready = 1'b1;
    lat_en     = 1'b1;

    // Good packet: header 0x0C, payload 11 22 33, parity 0x0C
    rc0 = read_cnt; bc0 = bytes_seen;
    pay_q.push_back(8'h11); pay_q.push_back(8'h22); pay_q.push_back(8'h33);
    send_pkt(2'b00, 3, 8'h00, 3);
    wait_done(1, "basic_done");
    chk("basic_reads", read_cnt - rc0, 5);
    chk("basic_bytes", bytes_seen - bc0, 3);

    // Same packet, parity 0x0D
    rc0 = read_cnt; bc0 = bytes_seen;
    pay_q.push_back(8'h11); pay_q.push_back(8'h22); pay_q.push_back(8'h33);
    send_pkt(2'b00, 3, 8'h01, 3);
    wait_done(2, "badpar_done");
    chk("badpar_reads", read_cnt - rc0, 5);
    chk("badpar_bytes", bytes_seen - bc0, 3);

    // Header 0x01: len 0, wrong address
    rc0 = read_cnt; bc0 = bytes_seen;
    send_pkt(2'b01, 0, 8'h00, 0);
    wait_done(3, "addr_done");
    chk("addr_reads", read_cnt - rc0, 2);
    chk("addr_bytes", bytes_seen - bc0, 0);

    // Back-to-back len 3 and len 63, both queued before the first is read
    rc0 = read_cnt; bc0 = bytes_seen;
    send_pkt(2'b00, 3, 8'h00, 3);
    send_pkt(2'b00, 63, 8'h00, 63);
    wait_done(5, "b2b_done");
    chk("b2b_reads", read_cnt - rc0, 70);
    chk("b2b_bytes", bytes_seen - bc0, 66);

    // FIFO runs dry after 2 of 5 payload bytes
    rc0 = read_cnt; bc0 = bytes_seen;
    send_pkt(2'b00, 5, 8'h00, 2);
    low_cnt = 0; n = 0;
    do begin
      @(negedge clock);
      n++;
      if (busy && !valid_out && !pkt_done) low_cnt++;
    end while (!pkt_done && n < 400);
    chk("timeout_seen", 32'(pkt_done), 1);
    chk("timeout_cycles", low_cnt, TIMEOUT);
    chk("timeout_reads", read_cnt - rc0, 3);
    chk("timeout_bytes", bytes_seen - bc0, 2);
    rc0 = read_cnt;
    repeat (10) @(negedge clock);
    chk("reads_after_abort", read_cnt - rc0, 0);
    @(posedge clock);
    #2;

    // Reset in the middle of the payload
    bc0 = bytes_seen;
    send_pkt(2'b00, 20, 8'h00, 20);
    n = 0;
    while (bytes_seen < bc0 + 5 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("rst_mid_pay_reached", 32'(bytes_seen >= bc0 + 5), 1);
    @(posedge clock);
    #2;
    resetn     = 1'b0;
    sink_ready = 1'b0;
    @(posedge clock);
    #2;
    resetn     = 1'b1;
    sink_ready = 1'b1;
    fifo.delete();
    exp_bytes.delete();
    exp_stat.delete();
    d0 = done_cnt;
    send_pkt(2'b00, 2, 8'h00, 2);
    @(negedge clock);
    check_idle("after_rst");
    wait_done(d0 + 1, "post_rst_done");

    // Randomized traffic: random lengths, addresses, parity faults, sink stalls, FIFO gaps
    lat_en    = 1'b0;
    rand_sink = 1'b1;
    rand_gap  = 1'b1;
    rc0       = read_cnt;
    d0        = done_cnt;
    exp_reads = 0;
    for (int p = 0; p < 25; p++) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 8));
      send_pkt(2'($urandom_range(0, 3)), len,
               ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, len);
      exp_reads += len + 2;
      if ($urandom_range(0, 1) == 0) wait_done(d0 + p + 1, "rand_done");
    end
    wait_done(d0 + 25, "rand_all_done");
    chk("rand_reads", read_cnt - rc0, exp_reads);
    rand_sink  = 1'b0;
    rand_gap   = 1'b0;
    sink_ready = 1'b1;

    chk("over_read", over_rd, 0);
    chk("exp_bytes_left", exp_bytes.size(), 0);
    chk("exp_stat_left", exp_stat.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_dest_reader.md
# router_dest_reader

- Destination-side consumer for one router output port (data_out_0/1/2 group).
- Watches the port's `valid_out`, then drives `read_enb` to drain one complete packet from the output FIFO: header, payload, parity.
- Checks the address and parity, streams payload bytes to a local sink, and reports per-packet status.
- Asserts its first read well inside the router's 30-cycle soft-reset window, so a healthy destination never triggers a flush.

## Interface
Parameters:
- `PORT_ID`, 2'b00 — address this instance serves; the header's addr field must match it.
- `WAIT_CYCLES`, 4 — cycles from `valid_out` seen high to the header read. Legal range 0..28; values above 28 are a configuration error.
- `TIMEOUT`, 32 — consecutive mid-packet cycles with `valid_out` low (no data) before the packet is aborted.

Ports:
- `clock` in 1 — single clock, all logic rising-edge.
- `resetn` in 1 — synchronous, active-low reset.
- `valid_out` in 1 — router port FIFO not empty.
- `data_out` in 8 — router port FIFO read data, valid one cycle after an accepted read.
- `sink_ready` in 1 — local sink can accept a byte this cycle.
- `read_enb` out 1 — read strobe to the router port FIFO.
- `byte_out` out 8 — payload byte to the sink.
- `byte_vld` out 1 — `byte_out` valid, one-cycle pulse per payload byte.
- `busy` out 1 — a packet is in progress (any state except IDLE).
- `pkt_done` out 1 — one-cycle pulse at the end of a packet, including aborted packets.
- `pkt_len` out 6 — header length field of the last packet, valid from the `pkt_done` pulse until the next header.
- `par_err` out 1 — parity mismatch; valid with `pkt_done`.
- `addr_err` out 1 — header addr ≠ `PORT_ID`; valid with `pkt_done`.
- `timeout_err` out 1 — packet aborted by timeout; valid with `pkt_done`.

## Operation
- Packet format:
  - Header: {len[7:2], addr[1:0]}.
  - Payload: len bytes (0..63).
  - Parity: XOR of the header and all payload bytes.
- FSM states: IDLE, WAIT, HDR_RD, HDR_CAP, PAY, DONE.
- IDLE:
  - When `valid_out`=1, go to WAIT and load the wait counter.
  - If `WAIT_CYCLES`=0, go directly to HDR_RD.
- WAIT:
  - Count down `WAIT_CYCLES`, then go to HDR_RD.
  - If `valid_out` drops, return to IDLE with no status.
- HDR_RD:
  - `read_enb` = `valid_out` & `sink_ready`.
  - Go to HDR_CAP on the first accepted read.
- HDR_CAP:
  - No read issued (one bubble).
  - Capture `data_out` into the header register and seed the parity accumulator with it.
  - Set the issue count to len+1 (payload + parity) and the receive count to len+1.
  - Go to PAY.
- PAY:
  - `read_enb` = `valid_out` & `sink_ready` & (issue count ≠ 0). Each accepted read decrements the issue count.
  - Each cycle after an accepted read, a byte arrives and the receive count decrements.
  - While the receive count > 1: the byte is payload. Drive `byte_out`/`byte_vld` and XOR it into the accumulator.
  - When the receive count = 1: the byte is parity. Compare it to the accumulator; `par_err` = mismatch.
  - Go to DONE after the parity byte.
- Over-read forbidden: the total reads per packet is exactly len+2, because the next packet may already be queued.
- DONE:
  - Pulse `pkt_done` with `par_err`, `addr_err`, `timeout_err`, `pkt_len` valid.
  - Go to IDLE.
  - A new packet may start the cycle after DONE.
- `addr_err` does not stop draining: the packet is still fully read and its payload still streamed.
- Timeout:
  - In HDR_RD or PAY, count consecutive cycles with reads owed and `valid_out`=0.
  - The count resets on any accepted read.
  - On reaching `TIMEOUT`: abort, stop reading, go to DONE with `timeout_err`=1 and `par_err`=0.
- Widths: the issue and receive counters are 7 bits (max 64). Counters never wrap; the FSM prevents decrement below 0.

## Timing
- Reset value of every output is 0, and the state is IDLE.
- Reset is effective mid-packet: the next cycle is IDLE with all outputs 0. No partial `pkt_done` is emitted.
- First `read_enb` lands `WAIT_CYCLES`+1 cycles after the first clock edge sampling `valid_out`=1, assuming `sink_ready`=1. This keeps it below 30.
- Data latency: `data_out` is sampled on the edge one cycle after the `read_enb` cycle. `byte_vld` is registered and asserts the cycle after that sample edge.
- Throughput: one byte per cycle in PAY while `valid_out` & `sink_ready`. There is a single bubble at HDR_CAP.
- `pkt_done` rises the cycle after the parity byte is captured.
- `sink_ready` low only withholds reads. Bytes already requested still arrive (the sink must absorb one in-flight byte).
- `valid_out` low with `sink_ready` low: the timeout still counts. `sink_ready` stalls do not count.

## Test plan
- Header 0x0C (len 3, addr 0), payload 0x11 0x22 0x33, parity 0x0C, `PORT_ID`=0 -> bytes out 11,22,33; exactly 5 `read_enb` cycles; `pkt_done` with `pkt_len`=3 and all errors 0.
- Same packet with parity 0x0D -> payload still streamed; `pkt_done` with `par_err`=1.
- Header 0x01 (len 0, addr 1), parity 0x01, `PORT_ID`=0 -> 2 reads, no `byte_vld`; `addr_err`=1, `par_err`=0.
- Two back-to-back packets of len 3 and len 63 queued -> no over-read; two `pkt_done` pulses; 66 payload bytes total in order.
- `valid_out` drops after 2 payload bytes and stays low 32 cycles -> `pkt_done` with `timeout_err`=1; `read_enb` stays 0 after the abort.
- `resetn` low mid-PAY for one cycle -> all outputs 0 the next cycle, state IDLE; with `valid_out` high, the header read occurs `WAIT_CYCLES`+1 cycles later.
